// File: rtl/pool2d_stream_if.sv
// Per-pixel stream bundle shared by the pooling stage and its neighbours:
// CHANNELS signed values per transfer plus valid/ready/last and a frame error flag.
interface pool2d_stream_if #(
  parameter int CHANNELS   = 4,
  parameter int VALUE_BITS = 18
);
  logic [CHANNELS-1:0][VALUE_BITS-1:0] i_data;
  logic [CHANNELS-1:0][VALUE_BITS-1:0] o_data;
  logic i_valid, i_ready, i_last;
  logic o_valid, o_ready, o_last, o_frame_err;

  modport master (
    output i_data, i_valid, i_last, o_ready,
    input  i_ready, o_data, o_valid, o_last, o_frame_err
  );

  modport slave (
    input  i_data, i_valid, i_last, o_ready,
    output i_ready, o_data, o_valid, o_last, o_frame_err
  );
endinterface

// File: rtl/pool2d_stream.sv
// Streaming KxK / stride S pooling (max or average) over a WIDTH x WIDTH
// row-major image; one accumulator row of OW windows is reused down the image.
module pool2d_stream #(
  parameter int WIDTH       = 28,
  parameter int CHANNELS    = 4,
  parameter int KERNEL_SIZE = 2,
  parameter int STRIDE      = 2,
  parameter int VALUE_BITS  = 18,
  parameter int N           = 12,
  parameter int MODE        = 0
) (
  input  logic            clk,
  input  logic            reset,
  pool2d_stream_if.slave  bus
);
  localparam int OW      = (WIDTH - KERNEL_SIZE) / STRIDE + 1;
  localparam int KK      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int LOG_KK  = $clog2(KK);
  localparam bit KK_POW2 = ((1 << LOG_KK) == KK);
  localparam int AW      = (MODE == 1) ? VALUE_BITS + LOG_KK : VALUE_BITS;
  localparam int PRW     = AW + N + 2;
  localparam int CW      = $clog2(WIDTH + 1);
  localparam int PW      = $clog2(STRIDE + 1);

  localparam logic signed [PRW-1:0] RECIP = PRW'(((1 << N) + KK / 2) / KK);
  localparam logic [CW-1:0] W_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] OW_LAST = CW'(OW - 1);
  localparam logic [PW-1:0] S_LAST  = PW'(STRIDE - 1);
  localparam logic [PW-1:0] K_LAST  = PW'(KERNEL_SIZE - 1);

  // Non-overlapping windows only: one accumulator per output column.
  generate
    if (STRIDE < KERNEL_SIZE) begin : g_bad_stride
      $error("pool2d_stream: STRIDE must not be smaller than KERNEL_SIZE");
    end
  endgenerate

  logic [CW-1:0] row, col, row_win, col_win;
  logic [PW-1:0] row_ph, col_ph;
  logic [OW-1:0][CHANNELS-1:0][AW-1:0] acc;

  logic fire, frame_end, early, in_win, first_px, done_px, last_win;
  logic signed [AW-1:0] px  [CHANNELS];
  logic signed [AW-1:0] cur [CHANNELS];
  logic signed [AW-1:0] upd [CHANNELS];
  logic [CHANNELS-1:0][VALUE_BITS-1:0] res;

  assign bus.i_ready = reset & (~bus.o_valid | bus.o_ready);
  assign fire      = bus.i_valid & bus.i_ready;
  assign frame_end = (row == W_LAST) && (col == W_LAST);
  assign early     = bus.i_last & ~frame_end;
  assign in_win    = (row_ph <= K_LAST) && (row_win <= OW_LAST) &&
                     (col_ph <= K_LAST) && (col_win <= OW_LAST);
  assign first_px  = (row_ph == '0) && (col_ph == '0);
  assign done_px   = (row_ph == K_LAST) && (col_ph == K_LAST);
  assign last_win  = (row_win == OW_LAST) && (col_win == OW_LAST);

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cur[c] = '0;
      for (int j = 0; j < OW; j++)
        if (col_win == CW'(j)) cur[c] = acc[j][c];
      px[c] = AW'($signed(bus.i_data[c]));
      if (first_px)       upd[c] = px[c];
      else if (MODE == 1) upd[c] = cur[c] + px[c];
      else                upd[c] = (px[c] > cur[c]) ? px[c] : cur[c];
      // Average: shift when K*K is a power of two, else fixed-point reciprocal.
      if (MODE == 0)   res[c] = VALUE_BITS'(upd[c]);
      else if (KK_POW2) res[c] = VALUE_BITS'(upd[c] >>> LOG_KK);
      else             res[c] = VALUE_BITS'((PRW'(upd[c]) * RECIP) >>> N);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0; col <= '0; row_win <= '0; col_win <= '0;
      row_ph <= '0; col_ph <= '0;
      acc <= '0;
      bus.o_data <= '0; bus.o_valid <= 1'b0; bus.o_last <= 1'b0;
      bus.o_frame_err <= 1'b0;
    end else begin
      bus.o_frame_err <= fire & (bus.i_last ^ frame_end);

      if (fire && in_win && done_px) begin
        bus.o_data  <= res;
        bus.o_valid <= 1'b1;
        bus.o_last  <= last_win & ~early;
      end else if (bus.o_ready) begin
        bus.o_valid <= 1'b0;
        bus.o_last  <= 1'b0;
      end

      if (fire && in_win)
        for (int j = 0; j < OW; j++)
          if (col_win == CW'(j))
            for (int c = 0; c < CHANNELS; c++) acc[j][c] <= upd[c];

      if (fire) begin
        if (frame_end || bus.i_last) begin
          row <= '0; col <= '0; row_win <= '0; col_win <= '0;
          row_ph <= '0; col_ph <= '0;
          if (early) acc <= '0;
        end else if (col == W_LAST) begin
          col <= '0; col_ph <= '0; col_win <= '0;
          row <= row + 1'b1;
          if (row_ph == S_LAST) begin
            row_ph  <= '0;
            row_win <= row_win + 1'b1;
          end else begin
            row_ph <= row_ph + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
          if (col_ph == S_LAST) begin
            col_ph  <= '0;
            col_win <= col_win + 1'b1;
          end else begin
            col_ph <= col_ph + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench: four pooling configurations share one stimulus/monitor path,
// selected by sel; expected outputs are hand-computed constants.
module tb_pool2d_stream;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][17:0] tdata;
  logic tvalid, tlast, ordy;
  int   sel;

  logic [1:0][17:0] mon_data;
  logic mon_irdy, mon_valid, mon_last, mon_err;

  int total = 0;
  int bad   = 0;
  int err_cnt;
  int q0[$], q1[$];
  bit ql[$];

  always #5 clk = ~clk;

  pool2d_stream_if #(.CHANNELS(2), .VALUE_BITS(18)) ifa ();
  pool2d_stream_if #(.CHANNELS(2), .VALUE_BITS(18)) ifb ();
  pool2d_stream_if #(.CHANNELS(2), .VALUE_BITS(18)) ifc ();
  pool2d_stream_if #(.CHANNELS(2), .VALUE_BITS(18)) ifd ();

  assign ifa.i_data = tdata; assign ifa.i_last = tlast; assign ifa.o_ready = ordy;
  assign ifb.i_data = tdata; assign ifb.i_last = tlast; assign ifb.o_ready = ordy;
  assign ifc.i_data = tdata; assign ifc.i_last = tlast; assign ifc.o_ready = ordy;
  assign ifd.i_data = tdata; assign ifd.i_last = tlast; assign ifd.o_ready = ordy;
  assign ifa.i_valid = tvalid && (sel == 0);
  assign ifb.i_valid = tvalid && (sel == 1);
  assign ifc.i_valid = tvalid && (sel == 2);
  assign ifd.i_valid = tvalid && (sel == 3);

  pool2d_stream #(.WIDTH(4), .CHANNELS(2), .KERNEL_SIZE(2), .STRIDE(2),
    .VALUE_BITS(18), .N(12), .MODE(0)) dut_max4 (.clk(clk), .reset(rst_n), .bus(ifa.slave));
  pool2d_stream #(.WIDTH(4), .CHANNELS(2), .KERNEL_SIZE(2), .STRIDE(2),
    .VALUE_BITS(18), .N(12), .MODE(1)) dut_avg4 (.clk(clk), .reset(rst_n), .bus(ifb.slave));
  pool2d_stream #(.WIDTH(3), .CHANNELS(2), .KERNEL_SIZE(3), .STRIDE(3),
    .VALUE_BITS(18), .N(12), .MODE(1)) dut_avg3 (.clk(clk), .reset(rst_n), .bus(ifc.slave));
  pool2d_stream #(.WIDTH(5), .CHANNELS(2), .KERNEL_SIZE(2), .STRIDE(2),
    .VALUE_BITS(18), .N(12), .MODE(0)) dut_max5 (.clk(clk), .reset(rst_n), .bus(ifd.slave));

  always_comb begin
    case (sel)
      1: begin mon_irdy = ifb.i_ready; mon_valid = ifb.o_valid; mon_data = ifb.o_data;
               mon_last = ifb.o_last; mon_err = ifb.o_frame_err; end
      2: begin mon_irdy = ifc.i_ready; mon_valid = ifc.o_valid; mon_data = ifc.o_data;
               mon_last = ifc.o_last; mon_err = ifc.o_frame_err; end
      3: begin mon_irdy = ifd.i_ready; mon_valid = ifd.o_valid; mon_data = ifd.o_data;
               mon_last = ifd.o_last; mon_err = ifd.o_frame_err; end
      default: begin mon_irdy = ifa.i_ready; mon_valid = ifa.o_valid; mon_data = ifa.o_data;
               mon_last = ifa.o_last; mon_err = ifa.o_frame_err; end
    endcase
  end

  // Inputs change just after posedge, so negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (rst_n && mon_valid && ordy) begin
      q0.push_back($signed(mon_data[0]));
      q1.push_back($signed(mon_data[1]));
      ql.push_back(mon_last);
    end
    if (rst_n && mon_err) err_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); ql.delete(); err_cnt = 0;
  endtask

  task automatic send(input int d0, input int d1, input bit last);
    bit acc = 1'b0;
    int n = 0;
    tdata[0] = 18'(d0); tdata[1] = 18'(d1); tlast = last; tvalid = 1'b1;
    do begin
      @(negedge clk); acc = mon_irdy;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", int'(acc), 1);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic ramp(input int npix, input int last_at);
    for (int p = 0; p < npix; p++) send(p, -p, p == last_at);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string t, input int i, input int e0, input int e1, input bit el);
    if (i < q0.size()) begin
      chk($sformatf("%s_ch0_%0d", t, i), q0[i], e0);
      chk($sformatf("%s_ch1_%0d", t, i), q1[i], e1);
      chk($sformatf("%s_last_%0d", t, i), int'(ql[i]), int'(el));
    end else begin
      chk($sformatf("%s_count", t), q0.size(), i + 1);
    end
  endtask

  task automatic chk_max4(input string t);
    chk({t, "_n"}, q0.size(), 4);
    chk_out(t, 0, 5, 0, 1'b0);
    chk_out(t, 1, 7, -2, 1'b0);
    chk_out(t, 2, 13, -8, 1'b0);
    chk_out(t, 3, 15, -10, 1'b1);
  endtask

  initial begin
    int v0;
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; ordy = 1'b1; sel = 0;
    tdata = '0; err_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irdy", int'(mon_irdy), 0);
    chk("rst_valid", int'(mon_valid), 0);
    chk("rst_last", int'(mon_last), 0);
    chk("rst_err", int'(mon_err), 0);
    chk("rst_data0", int'(mon_data[0]), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_irdy", int'(mon_irdy), 1);

    // Max pooling, 4x4 ramp
    sel = 0; clear_q();
    ramp(16, 15); drain();
    chk_max4("max4");
    chk("max4_err", err_cnt, 0);

    // Average 2x2: window 0 = 1.0, 2.0, 3.0, 4.0 in Q.12
    sel = 1; clear_q();
    for (int p = 0; p < 16; p++) begin
      case (p)
        0: v0 = 4096; 1: v0 = 8192; 4: v0 = 12288; 5: v0 = 16384;
        default: v0 = 0;
      endcase
      send(v0, -v0, p == 15);
      if (p == 4) chk("avg4_early_valid", int'(mon_valid), 0);
      if (p == 5) begin
        chk("avg4_lat_valid", int'(mon_valid), 1);
        chk("avg4_lat_data", $signed(mon_data[0]), 10240);
      end
    end
    drain();
    chk("avg4_n", q0.size(), 4);
    chk_out("avg4", 0, 10240, -10240, 1'b0);
    chk_out("avg4", 3, 0, 0, 1'b1);

    // Average 3x3 with reciprocal 455: 36864*455 >> 12 = 4095
    sel = 2; clear_q();
    for (int p = 0; p < 9; p++) send(4096, -4096, p == 8);
    drain();
    chk("avg3_n", q0.size(), 1);
    chk_out("avg3", 0, 4095, -4095, 1'b1);

    // Backpressure: output stalled, input must stall with it
    sel = 0; clear_q(); ordy = 1'b0;
    fork
      ramp(16, 15);
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!mon_valid && n < 100);
        chk("bp_seen", int'(mon_valid), 1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold_d0", $signed(mon_data[0]), 5);
          chk("bp_hold_d1", $signed(mon_data[1]), 0);
          chk("bp_irdy", int'(mon_irdy), 0);
        end
        @(posedge clk); #1;
        ordy = 1'b1;
      end
    join
    drain();
    chk_max4("bp");

    // 5x5: row 4 and column 4 carry large values that must be ignored
    sel = 3; clear_q();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        v0 = (y == 4 || x == 4) ? 1000 : y * 5 + x;
        send(v0, 100 - v0, (y == 4) && (x == 4));
      end
    drain();
    chk("w5_n", q0.size(), 4);
    chk_out("w5", 0, 6, 100, 1'b0);
    chk_out("w5", 1, 8, 98, 1'b0);
    chk_out("w5", 2, 16, 90, 1'b0);
    chk_out("w5", 3, 18, 88, 1'b1);
    chk("w5_err", err_cnt, 0);

    // Early i_last at pixel 6
    sel = 0; clear_q();
    ramp(7, 6); drain();
    chk("early_err", err_cnt, 1);
    chk("early_n", q0.size(), 1);
    chk_out("early", 0, 5, 0, 1'b0);
    clear_q();
    ramp(16, 15); drain();
    chk_max4("after_early");
    chk("after_early_err", err_cnt, 0);

    // Missing i_last: still wraps, o_last produced, error flagged
    clear_q();
    ramp(16, -1); drain();
    chk_max4("nolast");
    chk("nolast_err", err_cnt, 1);

    // Reset mid-frame while a result is pending
    clear_q();
    ramp(6, -1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(mon_valid), 0);
    chk("mid_rst_data0", int'(mon_data[0]), 0);
    chk("mid_rst_last", int'(mon_last), 0);
    chk("mid_rst_irdy", int'(mon_irdy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_q();
    ramp(16, 15); drain();
    chk_max4("after_rst");
    chk("after_rst_err", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
